// File: rtl/sys_bridge_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : sys_bridge_pkg                                             |
// | Description : Shared definitions for the CPU data-port bridge and its    |
// |               countdown timer: register offsets, FSM states, timer MODE  |
// |               encodings and CTRL bit positions.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package sys_bridge_pkg;

   // Timer register word offsets, selected by cpu_addr[3:2]
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   // Timer FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

   // MODE field encodings; the two unused codes act as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

endpackage

`default_nettype wire

// File: rtl/sys_bridge_timer_counter.sv
// +--------------------------------------------------------------------------+
// | Module      : timer_counter                                              |
// | Description : Programmable countdown timer with CTRL/PRESET/COUNT        |
// |               registers, a four-state sequencing FSM and an interrupt    |
// |               flag masked by CTRL.IM.                                    |
// | Ports       : clk   - system clock                                       |
// |               reset - asynchronous active-low reset                      |
// |               we    - full-word register write strobe                    |
// |               addr  - register word offset                               |
// |               wdata - write data                                         |
// |               rdata - combinational read data of the addressed register  |
// |               irq   - level interrupt request (irq_flag & IM)             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module timer_counter
   import sys_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   tc_state_e   state;
   tc_state_e   state_next;

   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic [31:0] count_next;
   logic        irq_flag;

   logic        flag_set;
   logic        flag_autoclr;
   logic        en_clear;
   logic        wr_ctrl;
   logic        wr_preset;

   assign wr_ctrl   = we && (addr == REG_CTRL);
   assign wr_preset = we && (addr == REG_PRESET);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, next-count and side-effect strobes
   always_comb begin
      state_next   = state;
      count_next   = count;
      flag_set     = 1'b0;
      flag_autoclr = 1'b0;
      en_clear     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl_en) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_next = preset;
            state_next = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_en) begin
               state_next = ST_IDLE;
            end else if (count > 32'd1) begin
               count_next = count - 32'd1;
            end else begin
               // A count of 0 (PRESET = 0) expires like a count of 1
               count_next = 32'd0;
               flag_set   = 1'b1;
               state_next = ST_INT;
            end
         end
         ST_INT: begin
            state_next = ST_IDLE;
            if (ctrl_mode == MODE_RELOAD) begin
               // EN stays set so IDLE reloads on the next cycle
               flag_autoclr = 1'b1;
            end else begin
               en_clear = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Register file, counter and interrupt flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         ctrl_im   <= 1'b0;
         preset    <= 32'd0;
         count     <= 32'd0;
         irq_flag  <= 1'b0;
      end else begin
         // A CPU write to CTRL overrides the FSM's one-shot EN clear
         if (wr_ctrl) begin
            ctrl_en   <= wdata[CTRL_EN];
            ctrl_mode <= wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            ctrl_im   <= wdata[CTRL_IM];
         end else if (en_clear) begin
            ctrl_en <= 1'b0;
         end

         if (wr_preset) begin
            preset <= wdata;
         end

         count <= count_next;

         // Setting the flag takes priority over any clearing source
         if (flag_set) begin
            irq_flag <= 1'b1;
         end else if (wr_ctrl || wr_preset || flag_autoclr) begin
            irq_flag <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (addr)
         REG_CTRL:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         REG_PRESET: rdata = preset;
         REG_COUNT:  rdata = count;
         default:    rdata = 32'd0;
      endcase
   end

   assign irq = irq_flag & ctrl_im;

endmodule

`default_nettype wire

// File: rtl/sys_bridge.sv
// +--------------------------------------------------------------------------+
// | Module      : sys_bridge                                                 |
// | Description : Address decoder between the CPU M-stage data port, the     |
// |               external data RAM and the internal countdown timer.        |
// |               Read data returns combinationally in the same cycle.       |
// | Ports       : clk, reset            - clock, async active-low reset      |
// |               cpu_addr/wdata/byteen - CPU data access                    |
// |               cpu_rdata             - combinational read data to CPU     |
// |               dm_addr/wdata/byteen  - data RAM access (byteen gated)     |
// |               dm_rdata              - RAM asynchronous read data         |
// |               irq                   - timer interrupt request            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sys_bridge
   import sys_bridge_pkg::*;
#(
   parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
   parameter logic [31:0] TC_BASE  = 32'h0000_7F00
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_byteen,
   output logic [31:0] cpu_rdata,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_byteen,
   input  logic [31:0] dm_rdata,
   output logic        irq
);

   logic        sel_dm;
   logic        sel_tc;
   logic        tc_we;
   logic [31:0] tc_rdata;

   assign sel_dm = (cpu_addr <= DM_LIMIT);
   assign sel_tc = (cpu_addr >= TC_BASE) && (cpu_addr <= (TC_BASE + 32'd11));

   // Only full-word accesses reach the timer registers
   assign tc_we = sel_tc && (cpu_byteen == 4'b1111);

   assign dm_addr   = cpu_addr;
   assign dm_wdata  = cpu_wdata;
   assign dm_byteen = sel_dm ? cpu_byteen : 4'b0000;

   timer_counter u_timer (
      .clk   (clk),
      .reset (reset),
      .we    (tc_we),
      .addr  (cpu_addr[3:2]),
      .wdata (cpu_wdata),
      .rdata (tc_rdata),
      .irq   (irq)
   );

   always_comb begin
      cpu_rdata = 32'd0;
      if (sel_dm) begin
         cpu_rdata = dm_rdata;
      end else if (sel_tc) begin
         cpu_rdata = tc_rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sys_bridge.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_sys_bridge                                              |
// | Description : Self-checking bench for sys_bridge: a vector table for     |
// |               decode and register access, plus directed timer sequences. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sys_bridge;

   localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic [31:0] cpu_wdata = 32'd0;
   logic [3:0]  cpu_byteen = 4'd0;
   logic [31:0] cpu_rdata;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_byteen;
   logic [31:0] dm_rdata = 32'd0;
   logic        irq;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] dmr;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be;
   } vec_t;

   vec_t vecs [20];

   sys_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_byteen (cpu_byteen),
      .cpu_rdata  (cpu_rdata),
      .dm_addr    (dm_addr),
      .dm_wdata   (dm_wdata),
      .dm_byteen  (dm_byteen),
      .dm_rdata   (dm_rdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Full-word write landing on the next rising edge; returns 1 time unit after it
   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cpu_addr   = a;
      cpu_wdata  = d;
      cpu_byteen = 4'hF;
      @(posedge clk);
      #1;
      cpu_byteen = 4'h0;
      cpu_wdata  = 32'd0;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      cpu_addr = a;
      #1;
      chk(name, cpu_rdata, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{32'h0000_0010, 32'h0,         4'b0011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0011};
      vecs[1]  = '{32'h0000_2FFF, 32'hA5A5_A5A5, 4'b1111, 32'h1111_2222, 32'h1111_2222, 4'b1111};
      vecs[2]  = '{32'h0000_3000, 32'h0,         4'b1111, 32'h0000_0055, 32'h0,         4'b0000};
      vecs[3]  = '{A_PRESET,      32'h1234_5678, 4'b1111, 32'h0000_AAAA, 32'h0,         4'b0000};
      vecs[4]  = '{A_PRESET,      32'h0,         4'b0000, 32'h0,         32'h1234_5678, 4'b0000};
      vecs[5]  = '{A_PRESET,      32'hFFFF_FFFF, 4'b0001, 32'h0,         32'h1234_5678, 4'b0000};
      vecs[6]  = '{A_PRESET,      32'h0,         4'b0000, 32'h0,         32'h1234_5678, 4'b0000};
      vecs[7]  = '{A_COUNT,       32'h0000_0099, 4'b1111, 32'h0,         32'h0,         4'b0000};
      vecs[8]  = '{A_COUNT,       32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000};
      vecs[9]  = '{32'h0000_5000, 32'h0,         4'b0000, 32'h0000_CAFE, 32'h0,         4'b0000};
      vecs[10] = '{32'h0000_7F10, 32'hFFFF_FFFF, 4'b1111, 32'h0,         32'h0,         4'b0000};
      vecs[11] = '{32'h0000_7EFF, 32'h0,         4'b0000, 32'h0000_1234, 32'h0,         4'b0000};
      vecs[12] = '{32'h0000_7F0C, 32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000};
      vecs[13] = '{A_CTRL,        32'h0000_00F6, 4'b1111, 32'h0,         32'h0,         4'b0000};
      vecs[14] = '{A_CTRL,        32'h0,         4'b0000, 32'h0,         32'h6,         4'b0000};
      vecs[15] = '{A_CTRL,        32'hFFFF_FFF0, 4'b0111, 32'h0,         32'h6,         4'b0000};
      vecs[16] = '{A_CTRL,        32'h0,         4'b1111, 32'h0,         32'h6,         4'b0000};
      vecs[17] = '{A_CTRL,        32'h0,         4'b0000, 32'h0,         32'h0,         4'b0000};
      vecs[18] = '{A_PRESET,      32'h0,         4'b0000, 32'h0,         32'h1234_5678, 4'b0000};
      vecs[19] = '{32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0077, 32'h0000_0077, 4'b0000};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rd_chk("reset_ctrl", A_CTRL, 32'd0);
      rd_chk("reset_preset", A_PRESET, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Decode and register access table
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cpu_addr   = vecs[i].addr;
         cpu_wdata  = vecs[i].wdata;
         cpu_byteen = vecs[i].be;
         dm_rdata   = vecs[i].dmr;
         #1;
         chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rd);
         chk($sformatf("vec%0d_dm_byteen", i), {28'd0, dm_byteen}, {28'd0, vecs[i].exp_be});
         chk($sformatf("vec%0d_dm_addr", i), dm_addr, vecs[i].addr);
         chk($sformatf("vec%0d_dm_wdata", i), dm_wdata, vecs[i].wdata);
         chk($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
      end
      @(negedge clk);
      cpu_byteen = 4'h0;
      dm_rdata   = 32'd0;

      // One-shot: PRESET=5, CTRL=EN|IM
      do_write(A_PRESET, 32'd5);
      do_write(A_CTRL, 32'h9);
      cpu_addr = A_COUNT;
      for (int k = 1; k <= 7; k++) begin
         next_cycle();
         chk($sformatf("oneshot_irq_k%0d", k), {31'd0, irq}, (k == 7) ? 32'd1 : 32'd0);
         if (k >= 2) begin
            chk($sformatf("oneshot_count_k%0d", k), cpu_rdata, 32'd7 - k);
         end
      end
      cpu_addr = A_CTRL;
      next_cycle();
      chk("oneshot_ctrl_en_cleared", cpu_rdata, 32'h8);
      repeat (3) next_cycle();
      chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
      rd_chk("oneshot_count_held", A_COUNT, 32'd0);
      do_write(A_CTRL, 32'h0);
      chk("oneshot_irq_cleared", {31'd0, irq}, 32'd0);

      // Auto-reload: PRESET=3, CTRL=EN|MODE01|IM -> 1-cycle pulse every 6 cycles
      do_write(A_PRESET, 32'd3);
      do_write(A_CTRL, 32'hB);
      cpu_addr = A_COUNT;
      for (int k = 1; k <= 18; k++) begin
         next_cycle();
         chk($sformatf("reload_irq_k%0d", k), {31'd0, irq},
             (k >= 5 && ((k - 5) % 6) == 0) ? 32'd1 : 32'd0);
      end

      // Auto-reload with IM=0: count cycles, irq stays low
      do_write(A_CTRL, 32'h0);
      repeat (3) next_cycle();
      do_write(A_CTRL, 32'h3);
      cpu_addr = A_COUNT;
      for (int k = 1; k <= 13; k++) begin
         next_cycle();
         chk($sformatf("nomask_irq_k%0d", k), {31'd0, irq}, 32'd0);
         if (k == 2 || k == 8) chk($sformatf("nomask_count_k%0d", k), cpu_rdata, 32'd3);
         if (k == 5) chk("nomask_count_k5", cpu_rdata, 32'd0);
      end

      // Same-edge collisions: PRESET write vs flag set, CTRL write vs EN clear
      do_write(A_CTRL, 32'h0);
      repeat (3) next_cycle();
      do_write(A_PRESET, 32'd2);
      do_write(A_CTRL, 32'h9);
      repeat (3) @(posedge clk);
      do_write(A_PRESET, 32'd2);
      chk("set_wins_irq", {31'd0, irq}, 32'd1);
      do_write(A_CTRL, 32'h9);
      chk("cpu_wins_irq", {31'd0, irq}, 32'd0);
      rd_chk("cpu_wins_ctrl", A_CTRL, 32'h9);
      repeat (2) @(posedge clk);
      #1;
      rd_chk("cpu_wins_reload_count", A_COUNT, 32'd2);

      // PRESET=0 behaves as PRESET=1
      repeat (10) next_cycle();
      do_write(A_PRESET, 32'd0);
      do_write(A_CTRL, 32'h9);
      next_cycle();
      next_cycle();
      chk("preset0_irq_k2", {31'd0, irq}, 32'd0);
      next_cycle();
      chk("preset0_irq_k3", {31'd0, irq}, 32'd1);

      // Asynchronous reset mid-count
      do_write(A_CTRL, 32'h0);
      repeat (2) next_cycle();
      do_write(A_PRESET, 32'd5);
      do_write(A_CTRL, 32'h9);
      cpu_addr = A_COUNT;
      repeat (5) next_cycle();
      chk("pre_reset_count", cpu_rdata, 32'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_irq", {31'd0, irq}, 32'd0);
      rd_chk("async_reset_count", A_COUNT, 32'd0);
      rd_chk("async_reset_ctrl", A_CTRL, 32'd0);
      rd_chk("async_reset_preset", A_PRESET, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cpu_addr = A_COUNT;
      repeat (5) next_cycle();
      chk("post_reset_idle_count", cpu_rdata, 32'd0);
      do_write(A_PRESET, 32'd2);
      do_write(A_CTRL, 32'h9);
      cpu_addr = A_COUNT;
      next_cycle();
      next_cycle();
      chk("post_reset_restart_count", cpu_rdata, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sys_bridge.md
Name: sys_bridge

Overview:
Sits directly downstream of the pipelined CPU's M-stage data port (addr/wdata/byteen out, rdata in). It decodes each data access and routes it either to the external data RAM or to an internal programmable countdown timer. It returns combinational read data in the same cycle and raises a timer interrupt line toward the CPU. It gives the core its first memory-mapped peripheral without changing the M-stage timing.

Parameters:
DM_LIMIT, 32'h0000_2FFF, last byte address mapped to data RAM (range starts at 0)
TC_BASE, 32'h0000_7F00, base address of timer register block (3 words)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
cpu_addr  in  32  CPU data address (M stage)
cpu_wdata  in  32  CPU write data, already byte-lane aligned
cpu_byteen  in  4  CPU byte enables; 4'b0000 = read/no write
cpu_rdata  out  32  read data to CPU, combinational
dm_addr  out  32  address to data RAM
dm_wdata  out  32  write data to data RAM
dm_byteen  out  4  byte enables to data RAM, gated by decode
dm_rdata  in  32  RAM read data (asynchronous read)
irq  out  1  timer interrupt request, level

Behaviour:
- Decode: sel_dm = cpu_addr <= DM_LIMIT; sel_tc = cpu_addr in [TC_BASE, TC_BASE+11]; otherwise unmapped.
- dm_addr = cpu_addr and dm_wdata = cpu_wdata always. dm_byteen = sel_dm ? cpu_byteen : 4'b0000.
- cpu_rdata: sel_dm -> dm_rdata; sel_tc -> the addressed timer register (by cpu_addr[3:2]); unmapped -> 32'h0. Zero-latency, purely combinational.
- Timer registers:
  - CTRL at +0: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, others behave as 00), bit3 IM; bits[31:4] read 0.
  - PRESET at +4: read/write.
  - COUNT at +8: read-only.
- Timer writes take effect only when sel_tc and cpu_byteen == 4'b1111. Partial-byte writes and writes to COUNT are dropped silently. Writes land at the clk rising edge.
- Timer FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if !EN, go to IDLE and hold COUNT. Else if COUNT > 1, COUNT <= COUNT-1. Else (COUNT is 1 or 0), COUNT <= 0, set irq_flag, go to INT.
  - INT, MODE 00: clear EN, go to IDLE.
  - INT, MODE 01: go to IDLE with EN still set, so the timer reloads (LOAD) next cycle.
- Period: the count reaches 0 and irq rises PRESET+2 cycles after the cycle EN is first seen in IDLE. PRESET = 0 behaves as PRESET = 1.
- irq = irq_flag & IM.
  - MODE 00: irq_flag stays set until a CPU write to CTRL or PRESET.
  - MODE 01: irq_flag auto-clears after one cycle (one-cycle pulse).
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state EN clear: the CPU-written value wins.
  - A CPU write that clears irq_flag in the same cycle the FSM sets it: set wins.
  - A write to PRESET during CNT does not affect the running count; it is used at the next LOAD.
- Reset (asynchronous, mid-operation allowed): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, so irq=0. cpu_rdata and dm_* follow their combinational equations from reset values.

Decomposition:
- Shared package holds:
  - timer register offsets (CTRL 2'd0, PRESET 2'd1, COUNT 2'd2);
  - FSM state encodings (IDLE, LOAD, CNT, INT);
  - MODE encodings;
  - CTRL bit positions.
- One sub-module, timer_counter: registers, FSM and irq_flag. Its ports are clk, reset, we, addr[1:0], wdata, rdata, irq.
- sys_bridge itself contains only the decode and muxing.

Test Plan:
- Reset, then cpu_addr=0x0000_0010, byteen=4'b0011 -> dm_byteen=4'b0011; with dm_rdata=0xDEADBEEF, cpu_rdata=0xDEADBEEF in the same cycle.
- Write 0x1234_5678 to 0x7F04 with byteen=4'b1111, then read it back -> 0x1234_5678 and dm_byteen=0. Repeat with byteen=4'b0001 -> register unchanged.
- PRESET=5, CTRL=0x9 (EN, IM, one-shot) -> COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after the CTRL write edge; EN reads 0 afterwards; irq stays high until CTRL is written with 0x0.
- PRESET=3, CTRL=0xB (auto-reload, IM) -> irq is a 1-cycle pulse repeating every 6 cycles. Same with IM=0 -> irq never asserts while COUNT still cycles.
- Read 0x0000_5000 and write 0x0000_7F10 -> cpu_rdata=0; dm_byteen=0; no timer register changes.
- Assert reset low mid-count (COUNT=2) -> immediately without a clock edge: irq=0, all timer registers read 0, state IDLE; counting resumes only after a new CTRL write.
